// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared constants for the data-memory arbiter:
//   - default address/data widths
//   - requester port indices (CPU = 0, debug/DMA loader = 1)
//   - width and type of the anti-starvation counter
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int AW_DEF   = 32;
  localparam int DW_DEF   = 32;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;
  localparam int NPORTS   = 2;

  localparam int CNT_W    = 4;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/rr_starve_ctr.sv
// -----------------------------------------------------------------------------
// rr_starve_ctr
// Two-port fixed-priority arbiter (CPU first) with an anti-starvation counter
// that forces a grant to the DMA port after MAX_CONSEC contended CPU wins.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_req_cpu   : CPU request
//   i_req_dma   : DMA/debug request
//   o_gnt_cpu   : CPU grant (combinational, forced low during reset)
//   o_gnt_dma   : DMA grant (combinational, forced low during reset)
// -----------------------------------------------------------------------------
module rr_starve_ctr
  import dmem_pkg::*;
#(
  parameter int MAX_CONSEC = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_cpu,
  input  logic i_req_dma,
  output logic o_gnt_cpu,
  output logic o_gnt_dma
);

  localparam cnt_t MAXC = cnt_t'(MAX_CONSEC);

  cnt_t r_cnt;
  logic w_force_dma;

  // Once the CPU has won MAXC contended cycles the DMA port takes the slot.
  // MAX_CONSEC = 0 therefore hands the DMA port every contended cycle.
  assign w_force_dma = (r_cnt >= MAXC);

  // Grants are gated by rst_n so nothing reaches memory while reset is held.
  assign o_gnt_dma = rst_n & i_req_dma & (~i_req_cpu | w_force_dma);
  assign o_gnt_cpu = rst_n & i_req_cpu & ~o_gnt_dma;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_req_dma || o_gnt_dma) begin
      r_cnt <= '0;
    end else if (o_gnt_cpu && (r_cnt < MAXC)) begin
      r_cnt <= r_cnt + cnt_t'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory between the CPU load/store path (port 0)
// and a debug/DMA loader (port 1). CPU has priority; the DMA port is guaranteed
// a slot after MAX_CONSEC contended cycles. Reads return one cycle after grant.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   m0_req/we/addr/wdata             : CPU request
//   m0_gnt, m0_stall                 : CPU accepted / CPU must hold PC
//   m0_rvalid, m0_rdata              : CPU registered read response
//   m1_req/we/addr/wdata             : DMA request
//   m1_gnt, m1_rvalid, m1_rdata      : DMA grant and registered read response
//   mem_addr/mem_wdata/mem_we        : memory drive (from granted port)
//   mem_dout                         : memory combinational read data
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int MAX_CONSEC = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_stall,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout
);

  logic [NPORTS-1:0] w_gnt;
  logic              w_rd0;
  logic              w_rd1;

  rr_starve_ctr #(
    .MAX_CONSEC (MAX_CONSEC)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req_cpu (m0_req),
    .i_req_dma (m1_req),
    .o_gnt_cpu (w_gnt[PORT_CPU]),
    .o_gnt_dma (w_gnt[PORT_DMA])
  );

  assign m0_gnt   = w_gnt[PORT_CPU];
  assign m1_gnt   = w_gnt[PORT_DMA];
  assign m0_stall = m0_req & ~m0_gnt;

  // Idle bus is driven to zero so memory sees no stray write or address.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (w_gnt[PORT_CPU]) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_we    = m0_we;
    end else if (w_gnt[PORT_DMA]) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_we    = m1_we;
    end
  end

  assign w_rd0 = m0_gnt & ~m0_we;
  assign w_rd1 = m1_gnt & ~m1_we;

  // Response registers: rvalid follows each read grant by one cycle, rdata
  // holds between responses. Reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= w_rd0;
      m1_rvalid <= w_rd1;
      if (w_rd0) begin
        m0_rdata <= mem_dout;
      end
      if (w_rd1) begin
        m1_rdata <= mem_dout;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory (`mem`) between two requesters:
  - port 0: the CPU load/store path.
  - port 1: a debug/DMA loader that preloads and inspects memory.
- Fixed priority to the CPU, with an anti-starvation counter that guarantees port 1 a slot after MAX_CONSEC contended cycles.
- Sits between the CPU data-memory signals (aluout>>2, regop2, memwe) and `mem`. Drives a stall to the CPU so the PC holds while the CPU is denied.

Parameters:
- AW, 32, word-address width (addresses are already word addresses, byte address >>2).
- DW, 32, data width.
- MAX_CONSEC, 3, consecutive contended CPU wins before port 1 is forced a grant. Legal 0..15; 0 gives port 1 priority under contention.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  CPU access request.
- m0_we  in  1  CPU write enable (1=write, 0=read).
- m0_addr  in  AW  CPU word address.
- m0_wdata  in  DW  CPU write data.
- m0_gnt  out  1  CPU access accepted this cycle (combinational).
- m0_stall  out  1  m0_req & ~m0_gnt; drives PC hold.
- m0_rvalid  out  1  CPU read data valid, one cycle after the read grant.
- m0_rdata  out  DW  CPU read data (registered).
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same definitions as port 0, for port 1.
- mem_addr  out  AW  to memory address.
- mem_wdata  out  DW  to memory write data.
- mem_we  out  1  to memory write enable (memory writes on clk).
- mem_dout  in  DW  memory combinational read data.

Behaviour:
- Reset (async, rst_n=0):
  - m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=0, starvation counter cnt=0.
  - Combinational outputs during reset: gnt=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - A read in flight when reset asserts is dropped; no rvalid is produced for it.
- Arbitration (combinational, every cycle):
  - Only m0_req: grant 0.
  - Only m1_req: grant 1.
  - Both: grant 1 if cnt>=MAX_CONSEC, else grant 0.
  - Neither: no grant; mem_we=0, mem_addr=0, mem_wdata=0.
  - At most one gnt high per cycle.
- Memory drive: mem_addr/mem_wdata come from the granted port. mem_we = granted port's we.
  - A write completes at the clk edge ending the grant cycle.
- cnt register (4 bits), updated on clk:
  - Cleared when m1_req=0 or m1_gnt=1.
  - Incremented when m0_gnt=1 and m1_req=1, saturating at MAX_CONSEC.
- Read response:
  - On the clk edge ending a read-grant cycle, the granted port's rdata <= mem_dout and its rvalid <= 1.
  - rvalid is a single-cycle pulse unless another read is granted to the same port in the following cycle (back-to-back reads give continuous rvalid).
  - rdata holds its last value between responses.
- Writes generate no rvalid.
- Latency:
  - Grant: 0 cycles when uncontended.
  - Read data: 1 cycle after grant.
  - Max port 1 wait under continuous contention: MAX_CONSEC cycles.
- A requester must hold req/we/addr/wdata stable until its gnt is seen. Dropping req before grant is legal; the request is simply withdrawn.
- Simultaneous read grant on one port and response for the other port: independent; no interaction.

Decomposition:
- Shared package dmem_pkg holds:
  - default AW/DW constants.
  - port index constants (PORT_CPU=0, PORT_DMA=1).
  - cnt width (4).
- No sub-module required.
  - The arbitration decision and cnt may optionally be a sub-module rr_starve_ctr.
  - Response registers stay in dmem_arbiter.

Test Plan:
- After reset (rst_n low 3 cycles, then high), no requests -> all gnt=0, rvalid=0, rdata=0, mem_we=0.
- m0 write addr 0x10 data 0xDEADBEEF, then m0 read 0x10 -> m0_gnt high each cycle. m0_rvalid pulses one cycle after the read grant with m0_rdata=0xDEADBEEF. m1 outputs stay idle.
- m0 and m1 both reading continuously, MAX_CONSEC=3 -> grant pattern 0,0,0,1,0,0,0,1… m0_stall high exactly on the port-1 cycles.
- m1 alone writes 0x20=0x12345678, then m0 reads 0x20 -> m0_rdata=0x12345678 one cycle after grant. mem_we never high on a read-grant cycle.
- Reset asserted mid-cycle of an m0 read grant -> rvalid stays 0 and cnt=0 after release. The first contended cycle after release grants port 0.
- MAX_CONSEC=0, both requesting -> port 1 granted every cycle, m0_stall held high, m1_rvalid continuously high for back-to-back reads.
